// File: rtl/track_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// track_ctrl_pkg
// Shared types and constants for the tracking mode controller.
//   mode_state_e       : state encoding of the auto/manual mode sequencer
//   MODE_AUTO/MANUAL   : value carried on the 'mode' output (RGB select)
//   KEY_*_DEFAULT      : PS/2 scan codes that request each mode
//   isSettleState()    : true for the two post-switch settle states
// ---------------------------------------------------------------------------
package track_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_AUTO        = 3'd0,
    ST_PEND_MAN    = 3'd1,
    ST_SETTLE_MAN  = 3'd2,
    ST_MANUAL      = 3'd3,
    ST_PEND_AUTO   = 3'd4,
    ST_SETTLE_AUTO = 3'd5
  } mode_state_e;

  localparam logic MODE_AUTO   = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;

  localparam logic [7:0] KEY_AUTO_DEFAULT   = 8'h1C;
  localparam logic [7:0] KEY_MANUAL_DEFAULT = 8'h3A;

  // Both settle states blank detect/shoot/target_off, so the outputs only
  // need to know whether the sequencer is in either of them.
  function automatic logic isSettleState(input mode_state_e s);
    return (s == ST_SETTLE_MAN) || (s == ST_SETTLE_AUTO);
  endfunction

endpackage

// File: rtl/shoot_limiter.sv
// ---------------------------------------------------------------------------
// shoot_limiter
// Turns a level shoot request into a rate-limited, fixed-length pulse.
//   clk         : system clock
//   reset       : asynchronous, active-low
//   shootLvl_i  : shoot request level from the selected tracker
//   enable_i    : requests are ignored while low (settle window)
//   shoot_o     : SHOOT_HOLD-cycle pulse, starting the cycle after acceptance
// A rising edge is accepted only once the cooldown counter has drained to 0;
// edges arriving earlier are dropped, never queued.
// ---------------------------------------------------------------------------
module shoot_limiter
  import track_ctrl_pkg::*;
#(
  parameter int SHOOT_HOLD = 1024,
  parameter int COOLDOWN   = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic shootLvl_i,
  input  logic enable_i,
  output logic shoot_o
);

  localparam int HoldW = $clog2(SHOOT_HOLD + 1);
  localparam int CoolW = $clog2(COOLDOWN + 1);

  localparam logic [HoldW-1:0] HoldLoad = HoldW'(SHOOT_HOLD - 1);
  localparam logic [CoolW-1:0] CoolLoad = CoolW'(COOLDOWN - 1);

  logic             shootPrev_q;
  logic             shoot_q;
  logic [HoldW-1:0] holdCnt_q;
  logic [CoolW-1:0] coolCnt_q;
  logic             request;
  logic             accept;

  // A request is a fresh rising edge of the level while enabled; it only
  // becomes a shot if the previous shot's cooldown has fully expired.
  assign request = shootLvl_i & ~shootPrev_q & enable_i;
  assign accept  = request & (coolCnt_q == '0);
  assign shoot_o = shoot_q;

  // Previous-level flop for edge detection. It tracks the level even while
  // disabled so that a level held high through the settle window does not
  // look like a new edge when the window closes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shootPrev_q <= 1'b0;
    end else begin
      shootPrev_q <= shootLvl_i;
    end
  end

  // Cooldown counter: loaded on acceptance, then counts down and sticks at
  // zero. Zero means "ready", which is also the reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coolCnt_q <= '0;
    end else if (accept) begin
      coolCnt_q <= CoolLoad;
    end else if (coolCnt_q != '0) begin
      coolCnt_q <= coolCnt_q - CoolW'(1);
    end
  end

  // Pulse stretcher: the output rises the cycle after acceptance and the
  // hold counter counts the remaining high cycles, so the pulse drops after
  // the cycle in which the counter is already zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shoot_q   <= 1'b0;
      holdCnt_q <= '0;
    end else if (accept) begin
      shoot_q   <= 1'b1;
      holdCnt_q <= HoldLoad;
    end else if (shoot_q) begin
      if (holdCnt_q == '0) begin
        shoot_q <= 1'b0;
      end else begin
        holdCnt_q <= holdCnt_q - HoldW'(1);
      end
    end
  end

endmodule

// File: rtl/track_mode_ctrl.sv
// ---------------------------------------------------------------------------
// track_mode_ctrl
// Selects between the auto (single-target) and manual (multi-target)
// tracking datapaths and owns every mode-dependent output.
//   clk, reset          : system clock, asynchronous active-low reset
//   v_sync              : VGA vertical sync, active-low pulse
//   key_data/key_valid  : PS/2 scan code and its one-cycle strobe
//   x_auto/y_auto, det_auto, shoot_auto, toff_auto : auto tracker inputs
//   x_man/y_man, det_man, shoot_man, toff_man      : manual mixer inputs
//   mode                : 0 = auto, 1 = manual (RGB select)
//   x_coor/y_coor       : frame-latched coordinates for the SPI slave
//   red_detect          : frame-latched detect
//   shoot_out           : rate-limited, stretched shoot pulse
//   target_off          : registered target_off of the selected source
//   settling            : high during the post-switch settle window
// Mode requests wait for a frame boundary before taking effect, then hold
// detect/shoot/target_off low for SETTLE_FRAMES frames.
// ---------------------------------------------------------------------------
module track_mode_ctrl
  import track_ctrl_pkg::*;
#(
  parameter logic [7:0] KEY_AUTO      = KEY_AUTO_DEFAULT,
  parameter logic [7:0] KEY_MANUAL    = KEY_MANUAL_DEFAULT,
  parameter int         SETTLE_FRAMES = 2,
  parameter int         SHOOT_HOLD    = 1024,
  parameter int         COOLDOWN      = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       v_sync,
  input  logic [7:0] key_data,
  input  logic       key_valid,
  input  logic [9:0] x_auto,
  input  logic [9:0] y_auto,
  input  logic       det_auto,
  input  logic       shoot_auto,
  input  logic       toff_auto,
  input  logic [9:0] x_man,
  input  logic [9:0] y_man,
  input  logic       det_man,
  input  logic       shoot_man,
  input  logic       toff_man,
  output logic       mode,
  output logic [9:0] x_coor,
  output logic [9:0] y_coor,
  output logic       red_detect,
  output logic       shoot_out,
  output logic       target_off,
  output logic       settling
);

  localparam int FrameW = $clog2(SETTLE_FRAMES + 1);
  localparam logic [FrameW-1:0] FrameLoad = FrameW'(SETTLE_FRAMES);

  logic              vSync1_q;
  logic              vSync2_q;
  logic              vSync3_q;
  logic              fb;

  mode_state_e       state_q;
  mode_state_e       state_d;
  logic              mode_q;
  logic              mode_d;
  logic [FrameW-1:0] frameCnt_q;
  logic [FrameW-1:0] frameCnt_d;
  logic              settling_q;
  logic              settling_d;

  logic [9:0]        xCoor_q;
  logic [9:0]        yCoor_q;
  logic              redDetect_q;
  logic              targetOff_q;

  logic              keyAuto;
  logic              keyManual;
  logic              shootSel;
  logic              shootPulse;

  assign keyAuto   = key_valid && (key_data == KEY_AUTO);
  assign keyManual = key_valid && (key_data == KEY_MANUAL);

  // Frame boundary = falling edge of the synchronised v_sync. The flops
  // reset high (the idle level of v_sync) so leaving reset never fakes an
  // edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vSync1_q <= 1'b1;
      vSync2_q <= 1'b1;
      vSync3_q <= 1'b1;
    end else begin
      vSync1_q <= v_sync;
      vSync2_q <= vSync1_q;
      vSync3_q <= vSync2_q;
    end
  end

  assign fb = vSync3_q & ~vSync2_q;

  // Next-state logic for the mode sequencer. Keys are looked at before the
  // frame boundary, so a pending request can be cancelled even in the very
  // cycle its boundary arrives, and a request made on a boundary cycle waits
  // for the following boundary. Keys are not examined at all while settling.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    frameCnt_d = frameCnt_q;
    case (state_q)
      ST_AUTO: begin
        if (keyManual) begin
          state_d = ST_PEND_MAN;
        end
      end
      ST_PEND_MAN: begin
        if (keyAuto) begin
          state_d = ST_AUTO;
        end else if (fb) begin
          state_d    = ST_SETTLE_MAN;
          mode_d     = MODE_MANUAL;
          frameCnt_d = FrameLoad;
        end
      end
      ST_SETTLE_MAN: begin
        if (fb) begin
          if (frameCnt_q <= FrameW'(1)) begin
            state_d    = ST_MANUAL;
            frameCnt_d = '0;
          end else begin
            frameCnt_d = frameCnt_q - FrameW'(1);
          end
        end
      end
      ST_MANUAL: begin
        if (keyAuto) begin
          state_d = ST_PEND_AUTO;
        end
      end
      ST_PEND_AUTO: begin
        if (keyManual) begin
          state_d = ST_MANUAL;
        end else if (fb) begin
          state_d    = ST_SETTLE_AUTO;
          mode_d     = MODE_AUTO;
          frameCnt_d = FrameLoad;
        end
      end
      ST_SETTLE_AUTO: begin
        if (fb) begin
          if (frameCnt_q <= FrameW'(1)) begin
            state_d    = ST_AUTO;
            frameCnt_d = '0;
          end else begin
            frameCnt_d = frameCnt_q - FrameW'(1);
          end
        end
      end
      default: begin
        state_d    = ST_AUTO;
        mode_d     = MODE_AUTO;
        frameCnt_d = '0;
      end
    endcase
    settling_d = isSettleState(state_d);
  end

  // Sequencer state plus its registered outputs (mode, settling), all
  // updated together so mode and settling never disagree for a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_AUTO;
      mode_q     <= MODE_AUTO;
      frameCnt_q <= '0;
      settling_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      frameCnt_q <= frameCnt_d;
      settling_q <= settling_d;
    end
  end

  // Coordinates and detect are captured once per frame from the source the
  // mode is switching to (the next-state value), so SPI always sees a set
  // taken from one tracker at one instant. Detect is blanked if the frame
  // that is starting is a settle frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xCoor_q     <= '0;
      yCoor_q     <= '0;
      redDetect_q <= 1'b0;
    end else if (fb) begin
      if (mode_d == MODE_MANUAL) begin
        xCoor_q     <= x_man;
        yCoor_q     <= y_man;
        redDetect_q <= det_man & ~settling_d;
      end else begin
        xCoor_q     <= x_auto;
        yCoor_q     <= y_auto;
        redDetect_q <= det_auto & ~settling_d;
      end
    end
  end

  // target_off follows the selected tracker every cycle, but is held low
  // while the newly selected tracker is still settling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      targetOff_q <= 1'b0;
    end else if (settling_d) begin
      targetOff_q <= 1'b0;
    end else if (mode_d == MODE_MANUAL) begin
      targetOff_q <= toff_man;
    end else begin
      targetOff_q <= toff_auto;
    end
  end

  // Shoot source follows the registered mode; the limiter's state is not
  // touched by mode changes, so a pulse or cooldown in progress carries over.
  assign shootSel = (mode_q == MODE_MANUAL) ? shoot_man : shoot_auto;

  shoot_limiter #(
    .SHOOT_HOLD(SHOOT_HOLD),
    .COOLDOWN  (COOLDOWN)
  ) u_shoot_limiter (
    .clk       (clk),
    .reset     (reset),
    .shootLvl_i(shootSel),
    .enable_i  (~settling_q),
    .shoot_o   (shootPulse)
  );

  assign mode       = mode_q;
  assign x_coor     = xCoor_q;
  assign y_coor     = yCoor_q;
  assign red_detect = redDetect_q;
  assign shoot_out  = shootPulse;
  assign target_off = targetOff_q;
  assign settling   = settling_q;

endmodule

// File: tb/tb_track_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_track_mode_ctrl
// Directed bench for track_mode_ctrl with SETTLE_FRAMES=2, SHOOT_HOLD=4,
// COOLDOWN=10. Expected output values are pushed to a queue as stimulus is
// applied and popped/compared once the DUT has had time to respond.
// ---------------------------------------------------------------------------
module tb_track_mode_ctrl;

  localparam logic [7:0] KeyAuto   = 8'h1C;
  localparam logic [7:0] KeyManual = 8'h3A;

  typedef enum int {F_MODE, F_X, F_Y, F_DET, F_SHOOT, F_TOFF, F_SETTLE} field_e;

  typedef struct {
    string      tag;
    field_e     field;
    logic [9:0] value;
  } expect_t;

  logic       clk;
  logic       reset;
  logic       v_sync;
  logic [7:0] key_data;
  logic       key_valid;
  logic [9:0] x_auto;
  logic [9:0] y_auto;
  logic       det_auto;
  logic       shoot_auto;
  logic       toff_auto;
  logic [9:0] x_man;
  logic [9:0] y_man;
  logic       det_man;
  logic       shoot_man;
  logic       toff_man;
  logic       mode;
  logic [9:0] x_coor;
  logic [9:0] y_coor;
  logic       red_detect;
  logic       shoot_out;
  logic       target_off;
  logic       settling;

  expect_t sbQueue[$];
  int      assertCount = 0;
  int      failCount   = 0;

  track_mode_ctrl #(
    .KEY_AUTO     (KeyAuto),
    .KEY_MANUAL   (KeyManual),
    .SETTLE_FRAMES(2),
    .SHOOT_HOLD   (4),
    .COOLDOWN     (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .v_sync    (v_sync),
    .key_data  (key_data),
    .key_valid (key_valid),
    .x_auto    (x_auto),
    .y_auto    (y_auto),
    .det_auto  (det_auto),
    .shoot_auto(shoot_auto),
    .toff_auto (toff_auto),
    .x_man     (x_man),
    .y_man     (y_man),
    .det_man   (det_man),
    .shoot_man (shoot_man),
    .toff_man  (toff_man),
    .mode      (mode),
    .x_coor    (x_coor),
    .y_coor    (y_coor),
    .red_detect(red_detect),
    .shoot_out (shoot_out),
    .target_off(target_off),
    .settling  (settling)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and land 1 unit after the edge, away from it.
  task automatic tickCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pad(input int n);
    repeat (n) tickCycle();
  endtask

  // Drop v_sync and advance to the cycle in which the DUT's frame-boundary
  // pulse is asserted (two synchroniser stages).
  task automatic fbArm();
    v_sync = 1'b0;
    tickCycle();
    tickCycle();
  endtask

  // Let the boundary take effect, then return v_sync to idle.
  task automatic fbFire();
    tickCycle();
    v_sync = 1'b1;
  endtask

  // One-cycle key strobe.
  task automatic applyStimulus(input logic [7:0] code);
    key_data  = code;
    key_valid = 1'b1;
    tickCycle();
    key_valid = 1'b0;
  endtask

  task automatic expectOut(input string tag, input field_e f, input logic [9:0] v);
    expect_t e;
    e.tag   = tag;
    e.field = f;
    e.value = v;
    sbQueue.push_back(e);
  endtask

  task automatic expectAll(input string tag, input logic m, input logic [9:0] x,
                           input logic [9:0] y, input logic d, input logic s,
                           input logic t, input logic st);
    expectOut({tag, ".mode"},       F_MODE,   {9'd0, m});
    expectOut({tag, ".x_coor"},     F_X,      x);
    expectOut({tag, ".y_coor"},     F_Y,      y);
    expectOut({tag, ".red_detect"}, F_DET,    {9'd0, d});
    expectOut({tag, ".shoot_out"},  F_SHOOT,  {9'd0, s});
    expectOut({tag, ".target_off"}, F_TOFF,   {9'd0, t});
    expectOut({tag, ".settling"},   F_SETTLE, {9'd0, st});
  endtask

  function automatic logic [9:0] observe(input field_e f);
    case (f)
      F_MODE:   return {9'd0, mode};
      F_X:      return x_coor;
      F_Y:      return y_coor;
      F_DET:    return {9'd0, red_detect};
      F_SHOOT:  return {9'd0, shoot_out};
      F_TOFF:   return {9'd0, target_off};
      F_SETTLE: return {9'd0, settling};
      default:  return '0;
    endcase
  endfunction

  // Drain the scoreboard against the DUT's present outputs.
  task automatic checkOutput();
    expect_t    e;
    logic [9:0] obs;
    while (sbQueue.size() > 0) begin
      e   = sbQueue.pop_front();
      obs = observe(e.field);
      assertCount++;
      assert (obs === e.value) else begin
        failCount++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.value);
      end
    end
  endtask

  // Directed sequence.
  initial begin
    reset      = 1'b0;
    v_sync     = 1'b1;
    key_data   = 8'h00;
    key_valid  = 1'b0;
    x_auto     = 10'd320;
    y_auto     = 10'd240;
    det_auto   = 1'b1;
    shoot_auto = 1'b0;
    toff_auto  = 1'b0;
    x_man      = 10'd100;
    y_man      = 10'd50;
    det_man    = 1'b1;
    shoot_man  = 1'b0;
    toff_man   = 1'b0;

    $display("[TB] reset and first frame latch");
    pad(3);
    expectAll("reset", 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput();
    reset = 1'b1;
    pad(20);
    expectOut("preFb.x_coor", F_X, 10'd0);
    checkOutput();
    fbArm();
    expectOut("fbArm.x_coor", F_X, 10'd0);
    checkOutput();
    fbFire();
    expectAll("fb1", 1'b0, 10'd320, 10'd240, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput();

    toff_auto = 1'b1;
    tickCycle();
    expectOut("toffAuto", F_TOFF, 10'd1);
    checkOutput();

    $display("[TB] shoot rate limiting");
    pad(10);
    for (int c = 0; c < 19; c++) begin
      shoot_auto = (c inside {0, 1, 5, 6, 12, 13});
      expectOut($sformatf("shootAuto.c%0d", c), F_SHOOT,
                (c inside {[1:4], [13:16]}) ? 10'd1 : 10'd0);
      checkOutput();
      tickCycle();
    end

    $display("[TB] ignored keys and cancelled request");
    applyStimulus(8'h55);
    applyStimulus(KeyAuto);
    pad(5);
    applyStimulus(KeyManual);
    pad(10);
    expectOut("pendMan.mode", F_MODE, 10'd0);
    checkOutput();
    applyStimulus(KeyAuto);
    pad(40);
    fbArm();
    fbFire();
    expectOut("cancel.mode", F_MODE, 10'd0);
    expectOut("cancel.settling", F_SETTLE, 10'd0);
    checkOutput();
    pad(90);
    fbArm();
    fbFire();
    expectOut("cancel2.mode", F_MODE, 10'd0);
    expectOut("cancel2.settling", F_SETTLE, 10'd0);
    checkOutput();

    $display("[TB] switch to manual");
    toff_man = 1'b1;
    pad(30);
    applyStimulus(KeyManual);
    pad(30);
    expectOut("midFrame.mode", F_MODE, 10'd0);
    expectOut("midFrame.settling", F_SETTLE, 10'd0);
    checkOutput();
    fbArm();
    expectOut("fbArmMan.mode", F_MODE, 10'd0);
    checkOutput();
    fbFire();
    expectAll("toMan.fb1", 1'b1, 10'd100, 10'd50, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput();
    shoot_man = 1'b1;
    pad(2);
    expectOut("settleShoot.a", F_SHOOT, 10'd0);
    checkOutput();
    pad(4);
    expectOut("settleShoot.b", F_SHOOT, 10'd0);
    checkOutput();
    shoot_man = 1'b0;
    x_man = 10'd200;
    pad(10);
    expectOut("holdMidFrame.x_coor", F_X, 10'd100);
    checkOutput();
    pad(60);
    fbArm();
    fbFire();
    expectAll("toMan.fb2", 1'b1, 10'd200, 10'd50, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput();
    pad(90);
    fbArm();
    fbFire();
    expectAll("toMan.done", 1'b1, 10'd200, 10'd50, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput();

    $display("[TB] switch back to auto");
    pad(20);
    applyStimulus(KeyAuto);
    pad(20);
    expectOut("pendAuto.mode", F_MODE, 10'd1);
    expectOut("pendAuto.target_off", F_TOFF, 10'd1);
    checkOutput();
    fbArm();
    fbFire();
    expectAll("toAuto.fb1", 1'b0, 10'd320, 10'd240, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput();
    pad(90);
    fbArm();
    fbFire();
    expectOut("toAuto.fb2.settling", F_SETTLE, 10'd1);
    expectOut("toAuto.fb2.red_detect", F_DET, 10'd0);
    checkOutput();
    pad(90);
    fbArm();
    fbFire();
    expectAll("toAuto.done", 1'b0, 10'd320, 10'd240, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput();

    $display("[TB] key on boundary cycle, key during settle");
    pad(20);
    fbArm();
    key_data  = KeyManual;
    key_valid = 1'b1;
    fbFire();
    key_valid = 1'b0;
    expectOut("keyOnFb.mode", F_MODE, 10'd0);
    expectOut("keyOnFb.settling", F_SETTLE, 10'd0);
    checkOutput();
    pad(90);
    fbArm();
    fbFire();
    expectOut("keyOnFb.next.mode", F_MODE, 10'd1);
    expectOut("keyOnFb.next.settling", F_SETTLE, 10'd1);
    checkOutput();
    pad(20);
    applyStimulus(KeyAuto);
    pad(60);
    fbArm();
    fbFire();
    expectOut("keyInSettle.mode", F_MODE, 10'd1);
    expectOut("keyInSettle.settling", F_SETTLE, 10'd1);
    checkOutput();
    pad(90);
    fbArm();
    fbFire();
    expectOut("keyInSettle.done.mode", F_MODE, 10'd1);
    expectOut("keyInSettle.done.settling", F_SETTLE, 10'd0);
    checkOutput();

    $display("[TB] async reset during pulse and pending switch");
    pad(20);
    applyStimulus(KeyAuto);
    pad(10);
    expectOut("preReset.mode", F_MODE, 10'd1);
    expectOut("preReset.target_off", F_TOFF, 10'd1);
    checkOutput();
    shoot_man = 1'b1;
    tickCycle();
    tickCycle();
    expectOut("preReset.shoot_out", F_SHOOT, 10'd1);
    checkOutput();
    #1 reset = 1'b0;
    #1;
    expectAll("asyncReset", 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput();
    shoot_man = 1'b0;
    pad(3);
    reset = 1'b1;
    tickCycle();
    shoot_auto = 1'b1;
    tickCycle();
    expectOut("postReset.shoot_out", F_SHOOT, 10'd1);
    expectOut("postReset.mode", F_MODE, 10'd0);
    checkOutput();
    shoot_auto = 1'b0;
    pad(90);
    fbArm();
    fbFire();
    expectAll("postReset.fb", 1'b0, 10'd320, 10'd240, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/track_mode_ctrl.md
Name: track_mode_ctrl

Overview:
- Sequences the two tracking datapaths (auto single-target, manual multi-target) and owns every mode-dependent output: VGA port select, target_off, and the coordinate/status word sent to the SPI slave.
- Mode changes come from PS/2 key codes and take effect only at a frame boundary, followed by a settle window.
- Coordinates are frame-latched so SPI always reads a coherent x/y/detect set.
- Shoot requests are rate-limited and pulse-stretched.
- Runs on sys_clk, between the trackers/mixers and slave_top. Replaces the current mux.

Parameters:
- KEY_AUTO, 8'h1C, key code that selects auto mode.
- KEY_MANUAL, 8'h3A, key code that selects manual mode.
- SETTLE_FRAMES, 2, frames with detect/shoot forced low after a switch; range 1..15.
- SHOOT_HOLD, 1024, cycles shoot_out stays high per accepted shot.
- COOLDOWN, 2_500_000, minimum cycles between accepted-shot rising edges; must be ≥ SHOOT_HOLD.

Ports:
- clk  in  1  sys_clk.
- reset  in  1  asynchronous, active-low.
- v_sync  in  1  VGA vertical sync, active-low pulse.
- key_data  in  8  PS/2 scan code.
- key_valid  in  1  one-cycle strobe; key_data is valid in that cycle.
- x_auto, y_auto  in  10 each  auto tracker aim point.
- det_auto, shoot_auto  in  1 each  auto tracker detect / shoot request (level).
- toff_auto  in  1  auto tracker target_off.
- x_man, y_man  in  10 each  manual mixer aim point.
- det_man, shoot_man  in  1 each  manual detect / shoot request (level).
- toff_man  in  1  manual tracker target_off.
- mode  out  1  0 = auto, 1 = manual; drives the RGB select.
- x_coor, y_coor  out  10 each  frame-latched coordinates to SPI.
- red_detect  out  1  frame-latched detect.
- shoot_out  out  1  stretched shoot pulse.
- target_off  out  1  registered selected target_off.
- settling  out  1  high during the settle window.

Behaviour:
- Reset (async assert, sync release): AUTO state; mode=0; x_coor=y_coor=0; red_detect=0; shoot_out=0; target_off=0; settling=0; counters=0; cooldown treated as expired.
- Frame boundary (fb): one-cycle pulse when registered v_sync goes 1→0. Use a two-flop sample, then edge detect; fb lags the pin by 2 cycles.
- FSM states: AUTO, PEND_MAN, SETTLE_MAN, MANUAL, PEND_AUTO, SETTLE_AUTO.
  - AUTO: key_valid with KEY_MANUAL → PEND_MAN.
  - PEND_MAN: fb → SETTLE_MAN; mode becomes 1 in that same cycle. KEY_AUTO here → back to AUTO (cancel).
  - SETTLE_MAN: frame counter loads SETTLE_FRAMES on entry and decrements per fb; → MANUAL on the fb where it reaches 0.
  - MANUAL, PEND_AUTO and SETTLE_AUTO mirror the above.
  - Keys other than the two codes are ignored. A key for the current mode is ignored.
  - A key during SETTLE_x is ignored; the user re-presses.
- fb and key_valid in the same cycle while in AUTO: the key is processed first, giving PEND_MAN. The switch waits for the next fb, so the mode never changes mid-frame.
- settling = 1 in SETTLE_* states.
- Latching: on each fb, x_coor/y_coor/red_detect load from the source selected by the mode value after that cycle's update. red_detect loads 0 if settling at that fb. Outputs hold between fbs.
- target_off: registered selected toff_*, updated every cycle; forced 0 while settling.
- Shoot:
  - Request = rising edge of the selected shoot_* level, gated by !settling.
  - Accepted only when the cooldown counter is 0. Acceptance loads the cooldown counter with COOLDOWN-1 and the hold counter with SHOOT_HOLD-1.
  - shoot_out goes high the cycle after acceptance, for exactly SHOOT_HOLD cycles.
  - Requests during cooldown are dropped, not queued.
  - A mode switch does not clear an in-flight pulse or cooldown.
- Counter widths: $clog2(param+1). No wrap; each counter saturates at 0.
- Reset asserted mid-operation: every state element clears immediately, with no partial pulse continuation.

Decomposition:
- Package track_ctrl_pkg: state enum mode_state_e, mode encoding constants MODE_AUTO/MODE_MANUAL, and default key code localparams.
- Sub-module shoot_limiter: edge detect + cooldown + hold counters, parameterised by SHOOT_HOLD/COOLDOWN, instantiated once.
- FSM, fb detect and latching stay in the top module.

Test Plan (bench parameters SETTLE_FRAMES=2, SHOOT_HOLD=4, COOLDOWN=10, frame = 100 cycles):
- Reset release, auto inputs x=320, y=240, det=1 → after the first fb: x_coor=320, y_coor=240, red_detect=1, mode=0.
- KEY_MANUAL mid-frame → mode stays 0 until the next fb. At that fb: mode=1, settling=1. red_detect latches 0 for 2 fbs. At the 3rd fb: red_detect=det_man, x_coor=x_man, settling=0.
- KEY_MANUAL then KEY_AUTO before any fb → no mode change and settling never asserts.
- shoot_auto rises at cycle t and again at t+5, t+12 → shoot_out high for t+1..t+4. The t+5 edge is dropped. The t+12 edge gives a pulse at t+13..t+16.
- shoot_man rising edge during SETTLE_MAN → shoot_out stays 0. toff_man=1 is also masked to target_off=0 while settling.
- Reset pulled low during a shoot pulse and PEND_AUTO → all outputs are 0 and mode=0 within the same cycle (async). After release, the first shoot edge is accepted immediately.
